pg_config_sequencer: RTL and testbench

PG_CONFIG_SEQUENCER -- requirements
Module: pg_config_sequencer

---
 rtl/pg_config_sequencer_pkg.sv | 57 +++++
 rtl/pg_cfg_mux.sv | 29 ++
 rtl/pg_config_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pg_config_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pg_config_sequencer_pkg.sv
// Address map, state encoding and shadow record shared by the pulse-generator config sequencer.
// Bus widths and the default target base address come from the DATA_WIDTH/ADDR_WIDTH/PG0_PULSE_ENA macros.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef PG0_PULSE_ENA
`define PG0_PULSE_ENA 8'h40
`endif

package pg_config_sequencer_pkg;
    localparam int unsigned DW = `DATA_WIDTH;
    localparam int unsigned AW = `ADDR_WIDTH;

    // Register offsets from BASE_ADDR, in programming order.
    localparam logic [3:0] OFF_PULSE_ENA      = 4'd0;
    localparam logic [3:0] OFF_USR_YEAR_H     = 4'd1;
    localparam logic [3:0] OFF_USR_YEAR_L     = 4'd2;
    localparam logic [3:0] OFF_USR_MONTH      = 4'd3;
    localparam logic [3:0] OFF_USR_DAY        = 4'd4;
    localparam logic [3:0] OFF_USR_HOUR       = 4'd5;
    localparam logic [3:0] OFF_USR_MINUTES    = 4'd6;
    localparam logic [3:0] OFF_USR_SECONDS    = 4'd7;
    localparam logic [3:0] OFF_WIDTH_HIGH_2   = 4'd8;
    localparam logic [3:0] OFF_WIDTH_HIGH_1   = 4'd9;
    localparam logic [3:0] OFF_WIDTH_HIGH_0   = 4'd10;
    localparam logic [3:0] OFF_WIDTH_PERIOD_2 = 4'd11;
    localparam logic [3:0] OFF_WIDTH_PERIOD_1 = 4'd12;
    localparam logic [3:0] OFF_WIDTH_PERIOD_0 = 4'd13;
    localparam logic [3:0] LAST_OFFSET        = OFF_WIDTH_PERIOD_0;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StDisable = 3'd1;
    localparam logic [2:0] StLoad    = 3'd2;
    localparam logic [2:0] StEnable  = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;
    localparam logic [2:0] StError   = 3'd5;

    // Per-register sub-phases used only when read-back verification is built in.
    localparam logic [1:0] PhWrite = 2'd0;
    localparam logic [1:0] PhRead  = 2'd1;
    localparam logic [1:0] PhCheck = 2'd2;

    typedef struct packed {
        logic [DW-1:0]   enable;
        logic [2*DW-1:0] year;
        logic [DW-1:0]   month;
        logic [DW-1:0]   day;
        logic [DW-1:0]   hour;
        logic [DW-1:0]   minutes;
        logic [DW-1:0]   seconds;
        logic [3*DW-1:0] width_high;
        logic [3*DW-1:0] width_period;
    } pg_cfg_t;
endpackage

// File: rtl/pg_cfg_mux.sv
// Selects the byte to write for a given register offset from the captured configuration.
module pg_cfg_mux
    import pg_config_sequencer_pkg::*;
(
    input  pg_cfg_t       cfg,
    input  logic [3:0]    offset,
    output logic [DW-1:0] data
);
    always_comb begin
        data = '0;
        case (offset)
            OFF_PULSE_ENA:      data = cfg.enable;
            OFF_USR_YEAR_H:     data = cfg.year[2*DW-1:DW];
            OFF_USR_YEAR_L:     data = cfg.year[DW-1:0];
            OFF_USR_MONTH:      data = cfg.month;
            OFF_USR_DAY:        data = cfg.day;
            OFF_USR_HOUR:       data = cfg.hour;
            OFF_USR_MINUTES:    data = cfg.minutes;
            OFF_USR_SECONDS:    data = cfg.seconds;
            OFF_WIDTH_HIGH_2:   data = cfg.width_high[3*DW-1:2*DW];
            OFF_WIDTH_HIGH_1:   data = cfg.width_high[2*DW-1:DW];
            OFF_WIDTH_HIGH_0:   data = cfg.width_high[DW-1:0];
            OFF_WIDTH_PERIOD_2: data = cfg.width_period[3*DW-1:2*DW];
            OFF_WIDTH_PERIOD_1: data = cfg.width_period[2*DW-1:DW];
            OFF_WIDTH_PERIOD_0: data = cfg.width_period[DW-1:0];
            default:            data = '0;
        endcase
    end
endmodule

// File: rtl/pg_config_sequencer.sv
// Programs one pulse-generator configuration: disable, load 13 registers, re-enable.
// Optional macro PG_SEQ_READBACK_EN adds a read-and-compare after every write.
module pg_config_sequencer
    import pg_config_sequencer_pkg::*;
#(
    parameter logic [`ADDR_WIDTH-1:0] BASE_ADDR = `PG0_PULSE_ENA
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [`DATA_WIDTH-1:0]   i_enable,
    input  logic [2*`DATA_WIDTH-1:0] i_year,
    input  logic [`DATA_WIDTH-1:0]   i_month,
    input  logic [`DATA_WIDTH-1:0]   i_day,
    input  logic [`DATA_WIDTH-1:0]   i_hour,
    input  logic [`DATA_WIDTH-1:0]   i_minutes,
    input  logic [`DATA_WIDTH-1:0]   i_seconds,
    input  logic [3*`DATA_WIDTH-1:0] i_width_high,
    input  logic [3*`DATA_WIDTH-1:0] i_width_period,
    output logic                     o_bus_req,
    input  logic                     i_bus_gnt,
    output logic                     o_wr,
    output logic [`ADDR_WIDTH-1:0]   o_addr,
    output logic [`DATA_WIDTH-1:0]   o_data,
    input  logic [`DATA_WIDTH-1:0]   i_rdata,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error
);
    logic [2:0]    state_q, state_d;
    logic [3:0]    offset_q, offset_d;
    pg_cfg_t       shadow_q, cfg_in;
    logic          capture, bad_cfg, in_bus, step, mismatch, write_phase;
    logic [3:0]    cur_off;
    logic [DW-1:0] mux_data;

    always_comb begin
        cfg_in.enable       = i_enable;
        cfg_in.year         = i_year;
        cfg_in.month        = i_month;
        cfg_in.day          = i_day;
        cfg_in.hour         = i_hour;
        cfg_in.minutes      = i_minutes;
        cfg_in.seconds      = i_seconds;
        cfg_in.width_high   = i_width_high;
        cfg_in.width_period = i_width_period;
    end

    assign capture = (state_q == StIdle) && i_start;
    assign bad_cfg = (i_width_period == '0) || (i_width_high >= i_width_period);
    assign in_bus  = (state_q == StDisable) || (state_q == StLoad) || (state_q == StEnable);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= StIdle;
            offset_q <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            if (capture) begin
                shadow_q <= cfg_in;
            end
        end
    end

`ifdef PG_SEQ_READBACK_EN
    logic [1:0] phase_q, phase_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            phase_q <= PhWrite;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Write, then a granted read of the same address, then compare the returned byte.
    always_comb begin
        phase_d  = phase_q;
        step     = 1'b0;
        mismatch = 1'b0;
        if (!in_bus) begin
            phase_d = PhWrite;
        end else begin
            case (phase_q)
                PhWrite: if (i_bus_gnt) phase_d = PhRead;
                PhRead:  if (i_bus_gnt) phase_d = PhCheck;
                default: begin
                    phase_d  = PhWrite;
                    mismatch = (i_rdata != o_data);
                    step     = (i_rdata == o_data);
                end
            endcase
        end
    end

    assign write_phase = (phase_q == PhWrite);
`else
    logic unused_rdata;

    assign unused_rdata = ^i_rdata;
    assign step         = i_bus_gnt;
    assign mismatch     = 1'b0;
    assign write_phase  = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        case (state_q)
            StIdle: begin
                if (i_start) begin
                    offset_d = OFF_PULSE_ENA;
                    state_d  = bad_cfg ? StError : StDisable;
                end
            end
            StDisable: begin
                if (mismatch) begin
                    state_d = StError;
                end else if (step) begin
                    state_d  = StLoad;
                    offset_d = OFF_USR_YEAR_H;
                end
            end
            StLoad: begin
                if (offset_q > LAST_OFFSET) begin
                    state_d = StIdle;
                end else if (mismatch) begin
                    state_d = StError;
                end else if (step) begin
                    if (offset_q == LAST_OFFSET) begin
                        state_d  = StEnable;
                        offset_d = OFF_PULSE_ENA;
                    end else begin
                        offset_d = offset_q + 4'd1;
                    end
                end
            end
            StEnable: begin
                if (mismatch) begin
                    state_d = StError;
                end else if (step) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cur_off = (state_q == StLoad) ? offset_q : OFF_PULSE_ENA;

    pg_cfg_mux u_cfg_mux (
        .cfg    (shadow_q),
        .offset (cur_off),
        .data   (mux_data)
    );

    // DISABLE and IDLE present a zero byte at BASE_ADDR.
    assign o_data    = ((state_q == StLoad) || (state_q == StEnable)) ? mux_data : '0;
    assign o_addr    = BASE_ADDR + AW'(cur_off);
    assign o_bus_req = in_bus;
    assign o_wr      = in_bus && i_bus_gnt && write_phase;
    assign o_busy    = in_bus || (capture && i_rst);
    assign o_done    = (state_q == StDone);
    assign o_error   = (state_q == StError);
endmodule

// File: tb/tb_pg_config_sequencer.sv
// Scoreboard bench for pg_config_sequencer; a small register-file model answers read-backs.
module tb_pg_config_sequencer;
    import pg_config_sequencer_pkg::*;

    localparam logic [AW-1:0] BASE = `PG0_PULSE_ENA;
    localparam int YW = 2 * DW;
    localparam int WW = 3 * DW;
`ifdef PG_SEQ_READBACK_EN
    localparam int CPW = 3;
`else
    localparam int CPW = 1;
`endif
    localparam int DONE_LAT = 15 * CPW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk, rst, start, gnt, corrupt;
    logic [DW-1:0] enable, month, day, hour, minutes, seconds, rdata;
    logic [YW-1:0] year;
    logic [WW-1:0] width_high, width_period;
    logic          bus_req, wr, busy, done, error;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  nwr = 0;
    int  ndone = 0;
    int  nerr = 0;
    int  done_cyc = 0;
    int  t0 = 0;
    wr_t sb[$];

    pg_config_sequencer #(.BASE_ADDR(BASE)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_enable       (enable),
        .i_year         (year),
        .i_month        (month),
        .i_day          (day),
        .i_hour         (hour),
        .i_minutes      (minutes),
        .i_seconds      (seconds),
        .i_width_high   (width_high),
        .i_width_period (width_period),
        .o_bus_req      (bus_req),
        .i_bus_gnt      (gnt),
        .o_wr           (wr),
        .o_addr         (addr),
        .o_data         (data),
        .i_rdata        (rdata),
        .o_busy         (busy),
        .o_done         (done),
        .o_error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr) mem[addr] <= data;
        rdata <= mem[addr] ^ ((corrupt && addr == BASE + 8'd3) ? 8'hFF : 8'h00);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic wr_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        return w;
    endfunction

    function automatic pg_cfg_t make_cfg(input logic [DW-1:0] en, input logic [YW-1:0] yr,
                                         input logic [DW-1:0] mo, input logic [DW-1:0] dy,
                                         input logic [DW-1:0] hr, input logic [DW-1:0] mi,
                                         input logic [DW-1:0] se, input logic [WW-1:0] wh,
                                         input logic [WW-1:0] wp);
        pg_cfg_t c;
        c.enable = en; c.year = yr; c.month = mo; c.day = dy; c.hour = hr;
        c.minutes = mi; c.seconds = se; c.width_high = wh; c.width_period = wp;
        return c;
    endfunction

    function automatic pg_cfg_t rand_cfg();
        logic [WW-1:0] wh;
        wh = WW'($urandom_range(0, 5000));
        return make_cfg(DW'($urandom), YW'($urandom), DW'($urandom), DW'($urandom),
                        DW'($urandom), DW'($urandom), DW'($urandom), wh,
                        wh + WW'($urandom_range(1, 5000)));
    endfunction

    task automatic drive_cfg(input pg_cfg_t c);
        enable = c.enable; year = c.year; month = c.month; day = c.day; hour = c.hour;
        minutes = c.minutes; seconds = c.seconds;
        width_high = c.width_high; width_period = c.width_period;
    endtask

    task automatic push_expected(input pg_cfg_t c);
        logic [DW-1:0] b [13];
        b = '{c.year[YW-1:DW], c.year[DW-1:0], c.month, c.day, c.hour, c.minutes, c.seconds,
              c.width_high[WW-1:2*DW], c.width_high[2*DW-1:DW], c.width_high[DW-1:0],
              c.width_period[WW-1:2*DW], c.width_period[2*DW-1:DW], c.width_period[DW-1:0]};
        sb.push_back(mk(BASE, '0));
        for (int i = 0; i < 13; i++) sb.push_back(mk(BASE + AW'(i + 1), b[i]));
        sb.push_back(mk(BASE, c.enable));
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the start pulse.
    task automatic start_seq(input pg_cfg_t c, input bit ok);
        drive_cfg(c);
        if (ok) push_expected(c);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        check_eq("busy_at_start", busy, 1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int limit);
        int base;
        bit seen;
        base = ndone + nerr;
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            if (ndone + nerr != base) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check_eq("end_within_budget", seen, 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (wr) begin
                nwr++;
                check_eq("wr_has_grant", bus_req & gnt, 1);
                check_eq("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    wr_t e;
                    e = sb.pop_front();
                    check_eq("wr_addr", addr, e.addr);
                    check_eq("wr_data", data, e.data);
                end
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
                check_eq("busy_at_done", {busy, bus_req}, 2'b00);
            end
            if (error) nerr++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        pg_cfg_t ca, cb, cc;
        int nw0, nd0, ne0;
        bit found;

        rst = 1'b0; start = 1'b0; gnt = 1'b1; corrupt = 1'b0;
        ca = make_cfg(8'h01, 16'h07E8, 8'h06, 8'h0F, 8'h0C, 8'h1E, 8'h2D, 24'h000005, 24'h00000A);
        drive_cfg(ca);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_outputs", {bus_req, wr, busy, done, error}, 5'b0);
        check_eq("rst_addr", addr, BASE);
        check_eq("rst_data", data, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Continuous grant, basic configuration.
        nw0 = nwr; nd0 = ndone; ne0 = nerr;
        start_seq(ca, 1);
        wait_end(200);
        check_eq("basic_done_lat", done_cyc - t0, DONE_LAT);
        check_eq("basic_writes", nwr - nw0, 15);
        check_eq("basic_counts", {ndone - nd0, nerr - ne0}, {32'd1, 32'd0});
        check_eq("basic_sb_drained", sb.size(), 0);
        repeat (2) @(posedge clk); #1;

        // Grant withheld for 4 cycles while offset 7 is pending.
        cb = rand_cfg();
        nw0 = nwr;
        start_seq(cb, 1);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus_req && addr == BASE + 8'd7) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check_eq("stall_reached_off7", found, 1);
        gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("stall_addr", addr, BASE + 8'd7);
            check_eq("stall_data", data, cb.seconds);
            check_eq("stall_no_wr", wr, 0);
            @(posedge clk); #1;
        end
        gnt = 1'b1;
        wait_end(200);
        check_eq("stall_done_lat", done_cyc - t0, DONE_LAT + 4);
        check_eq("stall_writes", nwr - nw0, 15);
        repeat (2) @(posedge clk); #1;

        // Invalid widths: error pulse, no bus activity.
        for (int k = 0; k < 2; k++) begin
            pg_cfg_t ce;
            ce = ca;
            ce.width_high = (k == 0) ? 24'h00000A : 24'h000000;
            ce.width_period = (k == 0) ? 24'h00000A : 24'h000000;
            nw0 = nwr;
            start_seq(ce, 0);
            @(negedge clk);
            check_eq("bad_cfg_error", {error, busy, bus_req}, 3'b100);
            @(negedge clk);
            check_eq("bad_cfg_error_pulse", error, 0);
            check_eq("bad_cfg_no_writes", nwr - nw0, 0);
            @(posedge clk); #1;
        end

        // Second start mid-sequence with changed inputs is ignored.
        cc = rand_cfg();
        nw0 = nwr; nd0 = ndone; ne0 = nerr;
        start_seq(cc, 1);
        repeat (5) @(posedge clk);
        #1;
        drive_cfg(rand_cfg());
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drive_cfg(ca);
        wait_end(200);
        check_eq("restart_counts", {ndone - nd0, nerr - ne0}, {32'd1, 32'd0});
        check_eq("restart_writes", nwr - nw0, 15);
        check_eq("restart_sb_drained", sb.size(), 0);
        repeat (2) @(posedge clk); #1;

        // Reset right after the offset-5 write.
        nw0 = nwr; nd0 = ndone;
        start_seq(ca, 1);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (wr && addr == BASE + 8'd5) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check_eq("reset_reached_off5", found, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("midrst_outputs", {bus_req, wr, busy, done, error}, 5'b0);
        check_eq("midrst_addr", addr, BASE);
        check_eq("midrst_data", data, 0);
        check_eq("midrst_writes_so_far", nwr - nw0, 6);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check_eq("post_rst_no_writes", nwr - nw0, 6);
        check_eq("post_rst_no_done", ndone - nd0, 0);

`ifdef PG_SEQ_READBACK_EN
        // Read-back of offset 3 returns a corrupted byte.
        corrupt = 1'b1;
        nw0 = nwr; nd0 = ndone; ne0 = nerr;
        start_seq(ca, 1);
        wait_end(300);
        check_eq("rb_err_counts", {ndone - nd0, nerr - ne0}, {32'd0, 32'd1});
        check_eq("rb_writes", nwr - nw0, 4);
        check_eq("rb_bus_req_dropped", bus_req, 0);
        check_eq("rb_sb_left", sb.size(), 11);
        sb.delete();
        repeat (20) @(posedge clk);
        #1;
        check_eq("rb_no_late_done", ndone - nd0, 0);
        corrupt = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
